sync_rx: RTL and testbench

Receiver for the framed serial stream produced by the team's sync-strobe transmitter. That transmitter drives a data bit on `q` together with a one-cycle `sync` strobe every PERIOD cycles. This block acquires lock on the strobe cadence, samples `q` on each strobe, assembles LSB-first words, and flags cadence and bit-pattern errors. It sits on the same clock as the transmitter, so no synchronizer is needed.

---
 rtl/sync_rx_if.sv | 9 +
 rtl/sync_rx.sv | 104 ++++++++++
 tb/tb_sync_rx.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sync_rx_if.sv
// sync_rx_if: serial stream in, assembled words and status out
// master: drives q_in/sync_in, observes results; slave: the receiver
interface sync_rx_if #(parameter int WIDTH = 8);
  logic q_in, sync_in;
  logic [WIDTH-1:0] data_out;
  logic data_valid, locked, sync_err, bit_err;
  modport master(output q_in, sync_in, input data_out, data_valid, locked, sync_err, bit_err);
  modport slave(input q_in, sync_in, output data_out, data_valid, locked, sync_err, bit_err);
endinterface

// File: rtl/sync_rx.sv
// sync_rx: locks to a periodic sync strobe, samples q_in on each strobe and assembles LSB-first words
// Ports: clk; reset (async, active-low); rx (sync_rx_if.slave): q_in, sync_in in; data_out, data_valid, locked, sync_err, bit_err out
module sync_rx #(
  parameter int WIDTH = 8,
  parameter int PERIOD = 3,
  parameter int LOCK_CNT = 2,
  parameter bit CHECK_ALT = 1
) (
  input logic clk,
  input logic reset,
  sync_rx_if.slave rx
);
  localparam int GW = $clog2(PERIOD + 1);
  localparam int CW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(WIDTH);
  localparam logic [GW-1:0] PER = GW'(PERIOD);
  localparam logic [CW-1:0] LCK = CW'(LOCK_CNT);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);
  typedef enum logic [1:0] {HUNT, ACQ, LOCK} state_t;
  state_t state, state_n;
  logic [GW-1:0] gap, gap_n;
  logic [CW-1:0] good, good_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [WIDTH-1:0] sh, sh_n, dout, dout_n;
  logic prev, prev_n, hp, hp_n, dv, dv_n, se, se_n, be, be_n;
  logic on_time, early, late;
  always_comb begin
    on_time = rx.sync_in && gap == PER;
    early = rx.sync_in && gap < PER;
    late = !rx.sync_in && gap == PER;
    state_n = state;
    gap_n = gap == PER ? gap : gap + 1'b1;
    good_n = good;
    bcnt_n = bcnt;
    sh_n = sh;
    dout_n = dout;
    prev_n = prev;
    hp_n = hp;
    dv_n = 1'b0;
    se_n = 1'b0;
    be_n = 1'b0;
    case (state)
      HUNT: if (rx.sync_in) begin
        state_n = ACQ;
        good_n = CW'(1);
        gap_n = GW'(1);
      end
      ACQ: if (rx.sync_in) begin
        gap_n = GW'(1);
        good_n = on_time ? good + 1'b1 : CW'(1);
        state_n = on_time && good + 1'b1 == LCK ? LOCK : ACQ;
      end else if (late) state_n = HUNT;
      LOCK: if (on_time) begin
        gap_n = GW'(1);
        sh_n = {rx.q_in, sh[WIDTH-1:1]};
        bcnt_n = bcnt == LAST ? '0 : bcnt + 1'b1;
        dv_n = bcnt == LAST;
        dout_n = bcnt == LAST ? sh_n : dout;
        // hp gates the check so the first sample after lock is never flagged
        be_n = CHECK_ALT && hp && rx.q_in == prev;
        prev_n = rx.q_in;
        hp_n = 1'b1;
      end else if (early || late) begin
        state_n = HUNT;
        se_n = 1'b1;
        bcnt_n = '0;
        sh_n = '0;
        hp_n = 1'b0;
      end
      default: state_n = HUNT;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= HUNT;
      gap <= '0;
      good <= '0;
      bcnt <= '0;
      sh <= '0;
      dout <= '0;
      prev <= 1'b0;
      hp <= 1'b0;
      dv <= 1'b0;
      se <= 1'b0;
      be <= 1'b0;
    end else begin
      state <= state_n;
      gap <= gap_n;
      good <= good_n;
      bcnt <= bcnt_n;
      sh <= sh_n;
      dout <= dout_n;
      prev <= prev_n;
      hp <= hp_n;
      dv <= dv_n;
      se <= se_n;
      be <= be_n;
    end
  assign rx.data_out = dout;
  assign rx.data_valid = dv;
  assign rx.locked = state == LOCK;
  assign rx.sync_err = se;
  assign rx.bit_err = be;
endmodule

// File: tb/tb_sync_rx.sv
// tb_sync_rx: directed scoreboard bench for sync_rx (CHECK_ALT=1 and CHECK_ALT=0 instances share stimulus)
module tb_sync_rx;
  logic clk = 1'b0, reset = 1'b0, s = 1'b0, q = 1'b0;
  always #5 clk = ~clk;
  sync_rx_if #(8) a();
  sync_rx_if #(8) b();
  assign a.sync_in = s;
  assign a.q_in = q;
  assign b.sync_in = s;
  assign b.q_in = q;
  sync_rx #(.WIDTH(8), .PERIOD(3), .LOCK_CNT(2), .CHECK_ALT(1)) dut (.clk(clk), .reset(reset), .rx(a.slave));
  sync_rx #(.WIDTH(8), .PERIOD(3), .LOCK_CNT(2), .CHECK_ALT(0)) dut0 (.clk(clk), .reset(reset), .rx(b.slave));
  typedef struct {logic [7:0] w; int c;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0, cyc = 0, base = 0;
  int n_dv = 0, n_se = 0, n_be = 0, n_be0 = 0, dv_cyc = 0, se_cyc = 0, be_cyc = 0;
  int k_dv, k_se, k_be, k_be0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (a.data_valid) begin
      n_dv++;
      dv_cyc = cyc - base + 1;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $error("FAIL unexpected_word: observed %0h expected none", a.data_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("word", a.data_out, e.w);
        if (e.c != 0) chk("word_cycle", dv_cyc, e.c);
      end
    end
    if (a.sync_err) begin n_se++; se_cyc = cyc - base + 1; end
    if (a.bit_err) begin n_be++; be_cyc = cyc - base + 1; end
    if (b.bit_err) n_be0++;
  end
  task automatic tick(input logic sv, input logic qv);
    s = sv;
    q = qv;
    @(negedge clk);
    #1;
  endtask
  task automatic frame(input logic qv);
    tick(1'b1, qv);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
  endtask
  task automatic word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) frame(w[i]);
  endtask
  task automatic snap;
    k_dv = n_dv; k_se = n_se; k_be = n_be; k_be0 = n_be0;
  endtask
  initial begin
    for (int i = 0; i < 6; i++) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    chk("rst_data_out", a.data_out, 0);
    chk("rst_flags", {a.data_valid, a.locked, a.sync_err, a.bit_err}, 0);
    chk("rst_no_events", n_dv + n_se + n_be, 0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
    chk("idle_locked", a.locked, 0);
    chk("idle_no_events", n_dv + n_se + n_be, 0);
    // nominal: strobes at cycles 1,4,7,...
    base = cyc;
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("pre_lock", a.locked, 0);
    tick(1'b1, 1'b0);
    chk("lock_cycle5", a.locked, 1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    sb.push_back('{8'h55, 29});
    sb.push_back('{8'h55, 53});
    snap();
    word(8'h55);
    word(8'h55);
    chk("nominal_words", n_dv - k_dv, 2);
    chk("nominal_errs", n_se + n_be - k_se - k_be, 0);
    chk("nominal_locked", a.locked, 1);
    // missing sync after 3 samples
    snap();
    frame(1'b1);
    frame(1'b0);
    frame(1'b1);
    chk("miss_pre_locked", a.locked, 1);
    tick(1'b0, 1'b0);
    chk("miss_sync_err", a.sync_err, 1);
    chk("miss_unlocked", a.locked, 0);
    tick(1'b0, 1'b0);
    chk("miss_err_pulse", n_se - k_se, 1);
    chk("miss_no_word", n_dv - k_dv, 0);
    frame(1'b0);
    frame(1'b1);
    chk("relock", a.locked, 1);
    sb.push_back('{8'h55, 0});
    word(8'h55);
    chk("relock_word", n_dv - k_dv, 1);
    // early strobe two cycles after a sample
    snap();
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    chk("early_sync_err", a.sync_err, 1);
    chk("early_unlocked", a.locked, 0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    frame(1'b0);
    chk("early_acq", a.locked, 0);
    frame(1'b0);
    chk("early_relock", a.locked, 1);
    chk("early_err_pulse", n_se - k_se, 1);
    // repeated bit: 1,1,0,1,0,1,0,1 -> 0xAB
    snap();
    base = cyc;
    sb.push_back('{8'hAB, 23});
    word(8'hAB);
    chk("biterr_count", n_be - k_be, 1);
    chk("biterr_cycle", be_cyc, 5);
    chk("biterr_off_count", n_be0 - k_be0, 0);
    chk("biterr_locked", a.locked, 1);
    chk("biterr_no_sync_err", n_se - k_se, 0);
    // repeat on the word-completing sample: bit_err and data_valid together
    snap();
    base = cyc;
    sb.push_back('{8'h2A, 23});
    word(8'h2A);
    chk("biterr_last_count", n_be - k_be, 1);
    chk("biterr_last_cycle", be_cyc, 23);
    chk("biterr_last_off", n_be0 - k_be0, 0);
    // reset after 5 samples
    for (int i = 0; i < 5; i++) frame(1'(i % 2 == 0));
    #1 reset = 1'b0;
    #1;
    chk("midrst_data_out", a.data_out, 0);
    chk("midrst_flags", {a.data_valid, a.locked, a.sync_err, a.bit_err}, 0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b1);
    reset = 1'b1;
    tick(1'b0, 1'b0);
    chk("postrst_locked", a.locked, 0);
    snap();
    base = cyc;
    sb.push_back('{8'h55, 29});
    frame(1'b1);
    frame(1'b0);
    word(8'h55);
    chk("postrst_word", n_dv - k_dv, 1);
    chk("postrst_no_err", n_se + n_be - k_se - k_be, 0);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
